// File: rtl/timer_dev_pkg.sv
// Shared register map, CTRL field positions, MODE encodings and FSM state
// encoding for the timer_dev memory-mapped timer.
package timer_dev_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_PSC    = 2'd3;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam int PSC_W = 16;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_CNT  = 2'd2;
  localparam state_t ST_INT  = 2'd3;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] nxt,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = nxt[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_regs.sv
// Bus decode, byte-enable merge and combinational read mux for timer_dev.
// With TIMER_PRESCALE_EN defined, offset 3 holds the 16-bit prescaler PSC.
module timer_regs
  import timer_dev_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [31:0]          wd,
  input  logic                 hw_clr_en,
  input  logic [31:0]          count,
  output logic [31:0]          rd,
  output logic [CTRL_W-1:0]    ctrl,
  output logic [31:0]          preset,
`ifdef TIMER_PRESCALE_EN
  output logic [PSC_W-1:0]     psc,
`endif
  output logic                 ctrl_wr,
  output logic                 preset_wr
);

  logic wr;

  assign wr        = sel & we;
  assign ctrl_wr   = wr && (addr == ADDR_W'(OFF_CTRL));
  assign preset_wr = wr && (addr == ADDR_W'(OFF_PRESET));

  // A bus write to CTRL overrides the one-shot hardware clear of EN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl   <= '0;
      preset <= '0;
    end else begin
      if (ctrl_wr && be[0]) ctrl <= wd[CTRL_W-1:0];
      else if (hw_clr_en)   ctrl[CTRL_EN] <= 1'b0;
      if (preset_wr) preset <= be_merge(preset, wd, be);
    end
  end

`ifdef TIMER_PRESCALE_EN
  logic psc_wr;

  assign psc_wr = wr && (addr == ADDR_W'(OFF_PSC));

  always_ff @(posedge clk) begin
    if (!reset) begin
      psc <= '0;
    end else if (psc_wr) begin
      if (be[0]) psc[7:0]  <= wd[7:0];
      if (be[1]) psc[15:8] <= wd[15:8];
    end
  end
`endif

  always_comb begin
    rd = '0;
    if (sel) begin
      case (addr)
        ADDR_W'(OFF_CTRL):   rd = {{(32-CTRL_W){1'b0}}, ctrl};
        ADDR_W'(OFF_PRESET): rd = preset;
        ADDR_W'(OFF_COUNT):  rd = count;
`ifdef TIMER_PRESCALE_EN
        ADDR_W'(OFF_PSC):    rd = {{(32-PSC_W){1'b0}}, psc};
`endif
        default:             rd = '0;
      endcase
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Programmable down-counting timer (one-shot / periodic) with maskable irq.
// Optional feature macro: TIMER_PRESCALE_EN (per-step prescaler at offset 3).
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       preset;
  logic [31:0]       count;
  logic              ctrl_wr;
  logic              preset_wr;
  state_t            state;
  logic              irq_flag;
  logic              en;
  logic              periodic;
  logic              tick;
  logic              expire;
  logic              hw_clr_en;

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0]  psc;
  logic [PSC_W-1:0]  psc_cnt;
`endif

  timer_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .addr      (addr),
    .we        (we),
    .be        (be),
    .wd        (wd),
    .hw_clr_en (hw_clr_en),
    .count     (count),
    .rd        (rd),
    .ctrl      (ctrl),
    .preset    (preset),
`ifdef TIMER_PRESCALE_EN
    .psc       (psc),
`endif
    .ctrl_wr   (ctrl_wr),
    .preset_wr (preset_wr)
  );

  assign en        = ctrl[CTRL_EN];
  assign periodic  = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_PERIODIC);
  assign hw_clr_en = (state == ST_INT) && !periodic;
  assign expire    = (state == ST_CNT) && en && tick && (count <= 32'd1);
  assign irq       = irq_flag & ctrl[CTRL_IM];

`ifdef TIMER_PRESCALE_EN
  // Up-counting prescaler: a count step fires every PSC+1 cycles; >= guards
  // against PSC being lowered below the running prescale value.
  assign tick = (psc_cnt >= psc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      psc_cnt <= '0;
    end else if (state == ST_LOAD) begin
      psc_cnt <= '0;
    end else if ((state == ST_CNT) && en) begin
      psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (expire) begin
            count <= '0;
            state <= ST_INT;
          end else if (tick) begin
            count <= count - 32'd1;
          end
        end
        ST_INT:  state <= (periodic && en) ? ST_LOAD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The flag rises on entry to INT so irq coincides with the INT cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_flag <= 1'b0;
    end else if (expire) begin
      irq_flag <= 1'b1;
    end else if ((state == ST_INT) && periodic) begin
      irq_flag <= 1'b0;
    end else if (ctrl_wr || preset_wr) begin
      irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized bus
// traffic checked against a behavioural model of the timer.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_dev #(.ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phases of a timer run as described by the register
  // semantics (idle, reload pending, counting, expired).
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_EXP  = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_phase;
`ifdef TIMER_PRESCALE_EN
  logic [15:0] m_psc;
  int          m_pre;
`endif

  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [3:0] b,
                            input logic [31:0] d, input bit rst_n);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset;
    logic [31:0] n_count;
    bit          n_flag;
    int          n_phase;
    bit          on;
    bit          repeat_mode;
    bit          step_now;
    bit          fired;
`ifdef TIMER_PRESCALE_EN
    logic [15:0] n_psc;
    int          n_pre;
`endif
    if (!rst_n) begin
      m_ctrl   = '0;
      m_preset = '0;
      m_count  = '0;
      m_flag   = 1'b0;
      m_phase  = PH_IDLE;
`ifdef TIMER_PRESCALE_EN
      m_psc    = '0;
      m_pre    = 0;
`endif
    end else begin
      on          = m_ctrl[0];
      repeat_mode = (m_ctrl[2:1] == 2'd1);
      n_ctrl      = m_ctrl;
      n_preset    = m_preset;
      n_count     = m_count;
      n_flag      = m_flag;
      n_phase     = m_phase;
      fired       = 1'b0;
`ifdef TIMER_PRESCALE_EN
      n_psc       = m_psc;
      n_pre       = m_pre;
      step_now    = (m_pre >= int'(m_psc));
`else
      step_now    = 1'b1;
`endif
      case (m_phase)
        PH_IDLE: if (on) n_phase = PH_LOAD;
        PH_LOAD: begin
`ifdef TIMER_PRESCALE_EN
          n_pre = 0;
`endif
          if (!on) n_phase = PH_IDLE;
          else begin
            n_count = m_preset;
            n_phase = PH_RUN;
          end
        end
        PH_RUN: begin
          if (!on) n_phase = PH_IDLE;
          else begin
`ifdef TIMER_PRESCALE_EN
            n_pre = step_now ? 0 : m_pre + 1;
`endif
            if (step_now) begin
              if (m_count <= 1) begin
                n_count = 0;
                n_phase = PH_EXP;
                fired   = 1'b1;
              end else begin
                n_count = m_count - 1;
              end
            end
          end
        end
        default: begin
          n_phase = (repeat_mode && on) ? PH_LOAD : PH_IDLE;
          if (!repeat_mode) n_ctrl[0] = 1'b0;
        end
      endcase
      if (fired) n_flag = 1'b1;
      else if (m_phase == PH_EXP && repeat_mode) n_flag = 1'b0;
      else if (wr && (a == 2'd0 || a == 2'd1)) n_flag = 1'b0;
      if (wr) begin
        if (a == 2'd0 && b[0]) n_ctrl = d[3:0];
        if (a == 2'd1) begin
          for (int k = 0; k < 4; k++) if (b[k]) n_preset[8*k +: 8] = d[8*k +: 8];
        end
`ifdef TIMER_PRESCALE_EN
        if (a == 2'd3) begin
          for (int k = 0; k < 2; k++) if (b[k]) n_psc[8*k +: 8] = d[8*k +: 8];
        end
`endif
      end
      m_ctrl   = n_ctrl;
      m_preset = n_preset;
      m_count  = n_count;
      m_flag   = n_flag;
      m_phase  = n_phase;
`ifdef TIMER_PRESCALE_EN
      m_psc    = n_psc;
      m_pre    = n_pre;
`endif
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
`ifdef TIMER_PRESCALE_EN
      default: return {16'b0, m_psc};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic logic model_irq();
    return m_flag & m_ctrl[3];
  endfunction

  // One clock with the given bus inputs; the model advances alongside.
  task automatic step(input logic s, input logic w, input logic [1:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic rst_n);
    sel   = s;
    we    = w;
    addr  = a;
    be    = b;
    wd    = d;
    reset = rst_n;
    model_edge(s & w, a, b, d, rst_n);
    @(posedge clk);
    #1;
    sel   = 1'b0;
    we    = 1'b0;
    reset = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b1, 1'b1, a, b, d, 1'b1);
  endtask

  task automatic rst_cycle();
    step(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    check_eq(tag, rd, exp);
    sel  = 1'b0;
    #1;
  endtask

  initial begin
    int          pulse_at[$];
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    int          r;

    reset = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    be    = 4'h0;
    wd    = 32'h0;
    rst_cycle();
    rst_cycle();

    // Reset hold after arbitrary writes
    wr(2'd1, 32'h0000_1234, 4'hF);
    wr(2'd0, 32'h0000_000B, 4'hF);
    idle(); idle(); idle();
    rst_cycle();
    rst_cycle();
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    read_chk("rst_ctrl", 2'd0, 32'd0);
    read_chk("rst_count", 2'd2, 32'd0);
    read_chk("rst_preset", 2'd1, 32'd0);
    addr = 2'd1;
    #1;
    check_eq("rd_nosel", rd, 32'd0);

    // Byte-enable merge
    wr(2'd1, 32'hAABB_CCDD, 4'b0100);
    read_chk("be_preset", 2'd1, 32'h00BB_0000);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    idle();
    check_eq("os_irq_pre", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      read_chk("os_count", 2'd2, 32'(5 - i));
      check_eq("os_irq", {31'b0, irq}, (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("os_irq_hold", {31'b0, irq}, 32'd1);
    end
    read_chk("os_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h8, 4'hF);
    check_eq("os_irq_clr", {31'b0, irq}, 32'd0);

    // Masked one-shot
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      idle();
      check_eq("mask_irq", {31'b0, irq}, 32'd0);
    end
    read_chk("mask_ctrl", 2'd0, 32'h0);
    read_chk("mask_count", 2'd2, 32'd0);

    // Periodic, PRESET=3
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int i = 1; i <= 26; i++) begin
      idle();
      if (irq) pulse_at.push_back(i);
    end
    check_eq("per_npulse", 32'(pulse_at.size()), 32'd5);
    if (pulse_at.size() > 0) check_eq("per_first", 32'(pulse_at[0]), 32'd5);
    for (int k = 1; k < pulse_at.size(); k++)
      check_eq("per_gap", 32'(pulse_at[k] - pulse_at[k-1]), 32'd5);
    wr(2'd0, 32'h0, 4'hF);
    idle(); idle();

    // PRESET write mid-count, EN=0 freeze, reload, reset mid-count
    wr(2'd1, 32'd6, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    idle(); idle(); idle();
    wr(2'd1, 32'd3, 4'hF);
    read_chk("mid_count_a", 2'd2, 32'd4);
    idle();
    read_chk("mid_count_b", 2'd2, 32'd3);
    wr(2'd0, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      idle();
      read_chk("freeze_count", 2'd2, 32'd2);
    end
    wr(2'd0, 32'h1, 4'hF);
    idle(); idle();
    read_chk("reload_count", 2'd2, 32'd3);
    idle();
    read_chk("reload_dec", 2'd2, 32'd2);
    rst_cycle();
    read_chk("midrst_count", 2'd2, 32'd0);
    read_chk("midrst_ctrl", 2'd0, 32'd0);
    idle(); idle();
    read_chk("midrst_idle", 2'd2, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescaled one-shot: PSC=2, PRESET=2
    wr(2'd3, 32'hFFFF_0002, 4'hF);
    read_chk("psc_rd", 2'd3, 32'd2);
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    for (int i = 1; i <= 9; i++) begin
      idle();
      if (i >= 2) read_chk("psc_count", 2'd2, (i < 5) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0);
      check_eq("psc_irq", {31'b0, irq}, (i >= 8) ? 32'd1 : 32'd0);
    end
`else
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    read_chk("off3_rd", 2'd3, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst_cycle();
      end else if (r < 16) begin
        a = 2'($urandom_range(0, 3));
        b = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
        case (a)
          2'd0: begin
            d    = $urandom;
            d[0] = ($urandom_range(0, 3) != 0);
          end
          2'd1:    d = 32'($urandom_range(0, 7));
          2'd3:    d = 32'($urandom_range(0, 3));
          default: d = $urandom;
        endcase
        wr(a, d, b);
      end else begin
        idle();
      end
      check_eq("rnd_irq", {31'b0, irq}, {31'b0, model_irq()});
      a = 2'($urandom_range(0, 3));
      read_chk("rnd_rd", a, model_rd(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped programmable timer that answers the CPU's system-bus master port (address, byte enables, write data, write enable, read data).
- Its interrupt output drives one of the CPU's six hardware-interrupt inputs, normally the HWInt[2] line.
- Sits behind the system bridge. The bridge decodes the device window and delivers a word-offset select plus gated write enable.
- Provides one-shot and periodic down-counting with a maskable interrupt.

Parameters:
- ADDR_W, 2: word-offset bits decoded inside the device (4 register slots).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets.
- sel  in  1  bridge device select for this timer.
- addr  in  ADDR_W  word offset, from bus address bits [3:2].
- we  in  1  write strobe. Effective only when sel=1.
- be  in  4  byte enables; be[i] gates byte i of wd.
- wd  in  32  write data.
- rd  out  32  read data.
- irq  out  1  interrupt request to CPU HWInt.

Behaviour:
- Register map:
  - offset 0: CTRL. [0]=EN, [2:1]=MODE, [3]=IM. Other bits read 0.
  - offset 1: PRESET, R/W, 32 bits.
  - offset 2: COUNT, read-only; writes ignored.
  - offset 3: reads 0, writes ignored.
- Reads:
  - rd is combinational from addr, with zero latency. This matches the CPU sampling read data in its memory stage.
  - rd=0 when sel=0.
- Writes:
  - Take effect at the next clk edge.
  - Only bytes with be[i]=1 are updated.
- Reset (reset=0 at the edge):
  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
  - Outputs: irq=0; rd=0 while sel=0.
  - A reset mid-count aborts the count immediately.
- FSM (one transition per cycle):
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds its value.
    - COUNT<=1 -> COUNT<=0, go to INT.
    - Otherwise COUNT<=COUNT-1.
  - INT, MODE=0 (one-shot):
    - Hardware clears EN; irq_flag<=1 -> IDLE.
    - irq_flag stays set until any bus write to CTRL or PRESET.
  - INT, MODE=1 (periodic):
    - irq_flag is high for this single cycle only -> LOAD.
  - MODE values 2 and 3 behave as MODE 0.
- irq = irq_flag & IM, registered-flag based and glitch-free.
- Timing:
  - Periodic with PRESET=N≥1: CNT lasts N cycles and the period is N+2 cycles.
  - PRESET=0 behaves as PRESET=1.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the INT-state EN clear: the bus write wins.
  - A PRESET write during CNT does not disturb COUNT; the new value is used at the next LOAD.
  - A CTRL write with EN=0 during LOAD or CNT returns to IDLE on the following edge.
- COUNT never wraps below 0.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- When defined:
  - Offset 3 becomes PSC (R/W, 16 bits; upper bits read 0).
  - An internal prescale counter reloads from PSC.
  - The CNT decrement happens only when the prescale counter reaches 0, so each count step lasts PSC+1 cycles.
  - The prescale counter clears in LOAD and on reset.
- When undefined:
  - Offset 3 reads 0 and ignores writes.
  - COUNT decrements every cycle.

Decomposition:
- Shared package: register offsets (CTRL/PRESET/COUNT/PSC), CTRL bit positions, MODE encodings, state encoding IDLE/LOAD/CNT/INT.
- One natural sub-module: timer_regs, holding the bus decode, byte-enable merge, and read mux.
- The FSM and counter stay in the top level.

Test Plan:
- Reset hold: reset=0 for 2 cycles after arbitrary writes -> CTRL=0, COUNT=0, irq=0.
- One-shot:
  - Stimulus: PRESET=5, CTRL=0x9 (EN, MODE0, IM).
  - Response: COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after the CTRL write and stays high; CTRL reads 0x8.
  - A write to CTRL then drops irq next cycle.
- Periodic:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Response: single-cycle irq pulses every 5 cycles, for at least 4 periods.
- Mask and byte enables:
  - IM=0 in one-shot: irq stays 0 while irq_flag is set.
  - Write 0xAABBCCDD to PRESET with be=4'b0100 -> PRESET reads 0x00BB0000.
- Mid-operation:
  - PRESET write during CNT -> COUNT is unaffected until the next reload.
  - EN=0 mid-count -> COUNT freezes.
  - reset=0 mid-count -> COUNT=0, state IDLE.
- With TIMER_PRESCALE_EN: PSC=2, PRESET=2, one-shot -> COUNT steps every 3 cycles; irq is asserted after the expected 2+6 cycles.
